// File: rtl/ras_resolver_if.sv
// ----------------------------------------------------------------------------
// ras_resolver_if
// Bundles the fetch-side prediction handshake, the execute-side resolution,
// the flush, and the repair/statistics outputs of the RAS resolver.
//   slave  : used by ras_resolver (consumes predictions/resolutions,
//            drives hit/restore/redirect/overflow/statistics)
//   master : used by the pipeline side (fetch/execute/flush sources)
// Signals:
//   pred_valid_i, pred_addr_i       fetch: RAS prediction leaving fetch
//   pred_ready_o                    tracker can accept a prediction
//   resolve_valid_i, resolve_pc_i   execute: oldest return resolves
//   flush_i                         pipeline flush
//   spec_hit_o                      prediction correct pulse
//   restore_o, restore_pc_o         RAS re-push request
//   redirect_o, redirect_pc_o       fetch redirect after a return miss
//   overflow_o                      sticky: prediction offered while not ready
//   hit_cnt_o, miss_cnt_o           statistics counters
// ----------------------------------------------------------------------------
interface ras_resolver_if #(
    parameter int CNT_W = 32
);
    logic              pred_valid_i;
    logic [31:0]       pred_addr_i;
    logic              pred_ready_o;
    logic              resolve_valid_i;
    logic [31:0]       resolve_pc_i;
    logic              flush_i;
    logic              spec_hit_o;
    logic              restore_o;
    logic [31:0]       restore_pc_o;
    logic              redirect_o;
    logic [31:0]       redirect_pc_o;
    logic              overflow_o;
    logic [CNT_W-1:0]  hit_cnt_o;
    logic [CNT_W-1:0]  miss_cnt_o;

    modport master (
        output pred_valid_i, pred_addr_i, resolve_valid_i, resolve_pc_i, flush_i,
        input  pred_ready_o, spec_hit_o, restore_o, restore_pc_o, redirect_o,
               redirect_pc_o, overflow_o, hit_cnt_o, miss_cnt_o
    );

    modport slave (
        input  pred_valid_i, pred_addr_i, resolve_valid_i, resolve_pc_i, flush_i,
        output pred_ready_o, spec_hit_o, restore_o, restore_pc_o, redirect_o,
               redirect_pc_o, overflow_o, hit_cnt_o, miss_cnt_o
    );
endinterface

// File: rtl/ras_resolver.sv
// ----------------------------------------------------------------------------
// ras_resolver
// Execute-side partner of the return address stack. Every RAS-predicted return
// is recorded in fetch order in a small tracking FIFO; when execute resolves
// the oldest one, the prediction is checked. A hit produces spec_hit_o; a miss
// makes the RAS re-push the consumed entry and redirects fetch, then a short
// MISS -> DRAIN repair sequence runs before tracking resumes. A flush clears
// the tracker and asks the RAS to restore the oldest outstanding entry.
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  asynchronous reset, ACTIVE-HIGH (1 = reset) despite the name
//   bus     ras_resolver_if.slave (see interface header for signal list)
// Parameters:
//   DEPTH   in-flight predicted returns tracked (power of 2, >= 2)
//   CNT_W   width of the statistics counters
// Configuration macro:
//   RAS_RESOLVER_STATS_EN  builds saturating hit/miss counters; without it
//                          hit_cnt_o/miss_cnt_o are tied to 0.
// ----------------------------------------------------------------------------
module ras_resolver #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    ras_resolver_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    typedef enum logic [1:0] {
        TRACK = 2'd0,
        MISS  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [31:0]    mem_q [DEPTH];

    logic           empty_s;
    logic           full_s;
    logic           ready_s;
    logic           push_s;
    logic           cmp_s;
    logic           hit_s;
    logic           miss_s;
    logic           flush_restore_s;
    logic [31:0]    head_s;

    logic           spec_hit_q;
    logic           restore_q;
    logic [31:0]    restore_pc_q;
    logic           redirect_q;
    logic [31:0]    redirect_pc_q;
    logic           overflow_q;

    // FIFO status and head entry derived from registered pointers only.
    always_comb begin
        empty_s = (wr_ptr_q == rd_ptr_q);
        full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        head_s  = mem_q[rd_ptr_q[AW-1:0]];
        ready_s = !full_s && (state_q == TRACK);
    end

    // Next-state, pointer update and hit/miss classification.
    always_comb begin
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        push_s          = 1'b0;
        cmp_s           = 1'b0;
        hit_s           = 1'b0;
        miss_s          = 1'b0;
        flush_restore_s = 1'b0;
        if (bus.flush_i) begin
            // Flush wins over everything: drop all entries, restore the oldest.
            flush_restore_s = !empty_s;
            rd_ptr_d        = wr_ptr_q;
            state_d         = TRACK;
        end else begin
            case (state_q)
                TRACK: begin
                    cmp_s = bus.resolve_valid_i && !empty_s;
                    if (cmp_s) begin
                        if (bus.resolve_pc_i == head_s) begin
                            hit_s = 1'b1;
                        end else begin
                            miss_s = 1'b1;
                        end
                    end else begin
                        hit_s  = 1'b0;
                        miss_s = 1'b0;
                    end
                    if (miss_s) begin
                        // Everything younger is wrong-path: a same-cycle push is dropped too.
                        rd_ptr_d = wr_ptr_q;
                        state_d  = MISS;
                    end else begin
                        // Push reads the pre-pop ready, so push+pop keeps the count.
                        push_s = bus.pred_valid_i && ready_s;
                        if (push_s) begin
                            wr_ptr_d = wr_ptr_q + PTR_ONE;
                        end else begin
                            wr_ptr_d = wr_ptr_q;
                        end
                        if (cmp_s) begin
                            rd_ptr_d = rd_ptr_q + PTR_ONE;
                        end else begin
                            rd_ptr_d = rd_ptr_q;
                        end
                    end
                end
                MISS:    state_d = DRAIN;
                DRAIN:   state_d = TRACK;
                default: state_d = TRACK;
            endcase
        end
    end

    // State and pointer registers.
    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            state_q  <= TRACK;
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Tracking FIFO storage.
    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.pred_addr_i;
        end
    end

    // Registered pulse/address outputs and the sticky overflow flag.
    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            spec_hit_q    <= 1'b0;
            restore_q     <= 1'b0;
            restore_pc_q  <= 32'h0000_0000;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'h0000_0000;
            overflow_q    <= 1'b0;
        end else begin
            spec_hit_q <= hit_s;
            restore_q  <= miss_s || flush_restore_s;
            redirect_q <= miss_s;
            if (miss_s || flush_restore_s) begin
                restore_pc_q <= head_s;
            end
            if (miss_s) begin
                redirect_pc_q <= bus.resolve_pc_i;
            end
            // Predictions offered during repair are expected and never flagged.
            if (bus.pred_valid_i && !ready_s && (state_q == TRACK)) begin
                overflow_q <= 1'b1;
            end
        end
    end

`ifdef RAS_RESOLVER_STATS_EN
    logic [CNT_W-1:0] hit_cnt_q;
    logic [CNT_W-1:0] miss_cnt_q;

    // Saturating hit/miss counters; flush restores are not misses.
    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            hit_cnt_q  <= {CNT_W{1'b0}};
            miss_cnt_q <= {CNT_W{1'b0}};
        end else begin
            if (hit_s && (hit_cnt_q != {CNT_W{1'b1}})) begin
                hit_cnt_q <= hit_cnt_q + CNT_W'(1);
            end
            if (miss_s && (miss_cnt_q != {CNT_W{1'b1}})) begin
                miss_cnt_q <= miss_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.hit_cnt_o  = hit_cnt_q;
    assign bus.miss_cnt_o = miss_cnt_q;
`else
    assign bus.hit_cnt_o  = {CNT_W{1'b0}};
    assign bus.miss_cnt_o = {CNT_W{1'b0}};
`endif

    assign bus.pred_ready_o  = ready_s;
    assign bus.spec_hit_o    = spec_hit_q;
    assign bus.restore_o     = restore_q;
    assign bus.restore_pc_o  = restore_pc_q;
    assign bus.redirect_o    = redirect_q;
    assign bus.redirect_pc_o = redirect_pc_q;
    assign bus.overflow_o    = overflow_q;

endmodule

// File: tb/tb_ras_resolver.sv
// ----------------------------------------------------------------------------
// tb_ras_resolver
// Scoreboard bench for ras_resolver (DEPTH=4, CNT_W=32). A behavioural model
// (queue of predicted addresses plus repair-state counter) computes the
// outputs expected one cycle after each driven cycle; these are queued at
// drive time and popped/compared by a monitor after the next rising edge.
// ----------------------------------------------------------------------------
module tb_ras_resolver;

    localparam int DEPTH = 4;
    localparam int CNT_W = 32;

    typedef struct packed {
        logic        hit;
        logic        restore;
        logic [31:0] rpc;
        logic        redirect;
        logic [31:0] dpc;
        logic        ovf;
        logic [31:0] hcnt;
        logic [31:0] mcnt;
    } exp_t;

    logic clk;
    logic rst;

    ras_resolver_if #(.CNT_W(CNT_W)) bus ();

    ras_resolver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i  (clk),
        .rst_ni (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks_s;
    int errors_s;

    exp_t        exp_q [$];
    logic [31:0] mq [$];
    int          mstate;     // 0 TRACK, 1 MISS, 2 DRAIN
    logic        movf;
    int          mhit;
    int          mmiss;
    logic [31:0] m_rpc;
    logic [31:0] m_dpc;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_s++;
        if (obs !== exp) begin
            errors_s++;
            $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mstate = 0;
        movf   = 1'b0;
        mhit   = 0;
        mmiss  = 0;
        m_rpc  = 32'h0;
        m_dpc  = 32'h0;
    endtask

    function automatic logic [31:0] exp_cnt(input int v);
`ifdef RAS_RESOLVER_STATS_EN
        return 32'(v);
`else
        return 32'(v) & 32'h0;
`endif
    endfunction

    // Drive one cycle of stimulus and queue the outputs it should produce.
    task automatic step(input logic pv, input logic [31:0] pa, input logic rv,
                        input logic [31:0] rpc, input logic fl);
        exp_t        e;
        logic        rdy;
        logic        cmp;
        logic        miss;
        logic [31:0] head;
        @(negedge clk);
        bus.pred_valid_i    = pv;
        bus.pred_addr_i     = pa;
        bus.resolve_valid_i = rv;
        bus.resolve_pc_i    = rpc;
        bus.flush_i         = fl;
        rdy  = (mq.size() < DEPTH) && (mstate == 0);
        miss = 1'b0;
        e    = '0;
        #1;
        check_eq("pred_ready", {31'b0, bus.pred_ready_o}, {31'b0, rdy});
        if (pv && !rdy && mstate == 0) movf = 1'b1;
        if (fl) begin
            if (mq.size() > 0) begin
                e.restore = 1'b1;
                m_rpc     = mq[0];
            end
            mq.delete();
            mstate = 0;
        end else if (mstate == 1) begin
            mstate = 2;
        end else if (mstate == 2) begin
            mstate = 0;
        end else begin
            cmp = rv && (mq.size() > 0);
            if (cmp) begin
                head = mq.pop_front();
                if (head == rpc) begin
                    e.hit = 1'b1;
                    mhit++;
                end else begin
                    miss       = 1'b1;
                    e.restore  = 1'b1;
                    e.redirect = 1'b1;
                    m_rpc      = head;
                    m_dpc      = rpc;
                    mq.delete();
                    mstate     = 1;
                    mmiss++;
                end
            end
            if (pv && rdy && !miss) mq.push_back(pa);
        end
        e.rpc  = m_rpc;
        e.dpc  = m_dpc;
        e.ovf  = movf;
        e.hcnt = exp_cnt(mhit);
        e.mcnt = exp_cnt(mmiss);
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("spec_hit",    {31'b0, bus.spec_hit_o}, {31'b0, e.hit});
            check_eq("restore",     {31'b0, bus.restore_o},  {31'b0, e.restore});
            check_eq("restore_pc",  bus.restore_pc_o,        e.rpc);
            check_eq("redirect",    {31'b0, bus.redirect_o}, {31'b0, e.redirect});
            check_eq("redirect_pc", bus.redirect_pc_o,       e.dpc);
            check_eq("overflow",    {31'b0, bus.overflow_o}, {31'b0, e.ovf});
            check_eq("hit_cnt",     bus.hit_cnt_o,           e.hcnt);
            check_eq("miss_cnt",    bus.miss_cnt_o,          e.mcnt);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"},    {31'b0, bus.pred_ready_o}, 32'h1);
        check_eq({tag, "_hit"},      {31'b0, bus.spec_hit_o},   32'h0);
        check_eq({tag, "_restore"},  {31'b0, bus.restore_o},    32'h0);
        check_eq({tag, "_rpc"},      bus.restore_pc_o,          32'h0);
        check_eq({tag, "_redirect"}, {31'b0, bus.redirect_o},   32'h0);
        check_eq({tag, "_dpc"},      bus.redirect_pc_o,         32'h0);
        check_eq({tag, "_ovf"},      {31'b0, bus.overflow_o},   32'h0);
        check_eq({tag, "_hcnt"},     bus.hit_cnt_o,             32'h0);
        check_eq({tag, "_mcnt"},     bus.miss_cnt_o,            32'h0);
    endtask

    initial begin
        checks_s = 0;
        errors_s = 0;
        model_reset();
        bus.pred_valid_i    = 1'b0;
        bus.pred_addr_i     = 32'h0;
        bus.resolve_valid_i = 1'b0;
        bus.resolve_pc_i    = 32'h0;
        bus.flush_i         = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // T1: hit
        step(1'b1, 32'h0000_1004, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 32'h0000_1004, 1'b0);
        idle();
        idle();

        // T2: miss, repair blocks fetch for two cycles, offers there are not overflow
        step(1'b1, 32'h0000_1004, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 32'h0000_2000, 1'b0);
        step(1'b1, 32'h0000_3000, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0000_3000, 1'b0, 32'h0, 1'b0);
        idle();
        step(1'b0, 32'h0, 1'b1, 32'h0000_3000, 1'b0);

        // T3: fill, overflow, push+resolve at count 3, drain with hits
        step(1'b1, 32'h0000_0100, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0000_0104, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0000_0108, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0000_010C, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0000_0110, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 32'h0000_0100, 1'b0);
        step(1'b1, 32'h0000_0200, 1'b1, 32'h0000_0104, 1'b0);
        step(1'b0, 32'h0, 1'b1, 32'h0000_0108, 1'b0);
        step(1'b0, 32'h0, 1'b1, 32'h0000_010C, 1'b0);
        step(1'b0, 32'h0, 1'b1, 32'h0000_0200, 1'b0);
        idle();

        // T4: flush with two entries, later resolve ignored
        step(1'b1, 32'h0000_00A0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0000_00B0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 32'h0000_00A0, 1'b0);
        idle();
        // flush beats a same-cycle push and resolve
        step(1'b1, 32'h0000_0700, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0000_0800, 1'b1, 32'h0000_0700, 1'b1);
        idle();
        // flush during MISS: nothing to restore
        step(1'b1, 32'h0000_0900, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 32'h0000_0904, 1'b0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        idle();

        // T5: resolve on empty FIFO, then reset during MISS
        step(1'b0, 32'h0, 1'b1, 32'h0000_0055, 1'b0);
        idle();
        step(1'b1, 32'h0000_0500, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 32'h0000_0600, 1'b0);
        @(posedge clk);
        #2;
        check_eq("t5_restore_pre", {31'b0, bus.restore_o}, 32'h1);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_miss");
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // T6: three hits and one miss from a clean reset
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h0000_4000 + 32'(i * 4), 1'b0, 32'h0, 1'b0);
            step(1'b0, 32'h0, 1'b1, 32'h0000_4000 + 32'(i * 4), 1'b0);
        end
        step(1'b1, 32'h0000_5000, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 32'h0000_5004, 1'b0);
        idle();
        idle();
        idle();

        // Random mix of pushes, resolves and occasional flushes
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)),
                 32'h40 + 32'($urandom_range(0, 1) * 4),
                 1'($urandom_range(0, 1)),
                 32'h40 + 32'($urandom_range(0, 1) * 4),
                 ($urandom_range(0, 15) == 0));
        end
        idle();
        @(posedge clk);
        #3;
        check_eq("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks_s, errors_s);
        $finish;
    end

endmodule
